tf_fetch: RTL and testbench

Twiddle-factor fetch engine for one radix stage of the 8192-point FFT. On a start pulse it reads the stage's twiddle-factor ROM and streams the entries into the downstream 8-entry twiddle FIFO. Entries go in address order, 0..tf_num-1, repeated for a programmable number of passes. A 2-entry skid buffer absorbs the 1-cycle ROM read latency, so the engine honours FIFO `full` back-pressure without losing words and sustains one word per cycle when the FIFO is not full.

---
 rtl/tf_fetch_pkg.sv | 12 +
 rtl/tf_fetch_if.sv | 26 ++
 rtl/tf_fetch_skid2.sv | 58 +++++
 rtl/tf_fetch.sv | 94 +++++++++
 tb/tb_tf_fetch.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/tf_fetch_pkg.sv
// Shared FFT constants: operand widths, twiddle ROM geometry and the complex
// word layout used by the twiddle fetch, twiddle FIFO and butterfly.
package tf_fetch_pkg;
    localparam int float_len        = 32;
    localparam int tf_num           = 8;
    localparam int bram_tf_addr_len = 3;
    localparam int bram_addr_len    = 13;
    localparam int cword_len        = 2 * float_len;

    // real part in the upper half, imag in the lower half
    typedef logic [cword_len-1:0] cword_t;
endpackage

// File: rtl/tf_fetch_if.sv
// Control, ROM-read and FIFO-write signals of the twiddle fetch engine.
// master = the fetch engine, slave = the controller/ROM/FIFO side.
interface tf_fetch_if;
    import tf_fetch_pkg::*;

    logic                        start;
    logic [bram_addr_len-1:0]    pass_num;
    logic                        busy;
    logic                        done;
    logic                        tf_rd_en;
    logic [bram_tf_addr_len-1:0] tf_addr;
    cword_t                      tf_data;
    logic                        fifo_full;
    logic                        fifo_wr_en;
    cword_t                      fifo_din;

    modport master (
        input  start, pass_num, tf_data, fifo_full,
        output busy, done, tf_rd_en, tf_addr, fifo_wr_en, fifo_din
    );

    modport slave (
        output start, pass_num, tf_data, fifo_full,
        input  busy, done, tf_rd_en, tf_addr, fifo_wr_en, fifo_din
    );
endinterface

// File: rtl/tf_fetch_skid2.sv
// Two-entry FIFO-order skid buffer; entry 0 is always the head.
// The caller never pushes when full nor pops when empty.
module tf_skid2 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   cnt
);
    logic [W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]   cnt_q, cnt_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) ent0_d = push_data;
                else               ent1_d = push_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // count is unchanged; the incoming word lands behind the survivor
                if (cnt_q == 2'd1) begin
                    ent0_d = push_data;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head = ent0_q;
    assign cnt  = cnt_q;
endmodule

// File: rtl/tf_fetch.sv
// Twiddle-factor fetch engine: sweeps the stage ROM pass_num times and streams
// the words into the twiddle FIFO through a 2-entry skid honouring fifo_full.
module tf_fetch #(
    parameter int float_len        = tf_fetch_pkg::float_len,
    parameter int tf_num           = tf_fetch_pkg::tf_num,
    parameter int bram_tf_addr_len = tf_fetch_pkg::bram_tf_addr_len,
    parameter int bram_addr_len    = tf_fetch_pkg::bram_addr_len
) (
    input logic        clk,
    input logic        rst,
    tf_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                      state_q, state_d;
    logic [bram_tf_addr_len-1:0] addr_q, addr_d;
    logic [bram_addr_len-1:0]    pass_q, pass_d;
    logic [bram_addr_len-1:0]    pass_num_q, pass_num_d;
    logic                        inflight_q, inflight_d;

    logic [1:0]               cnt;
    logic [2*float_len-1:0]   head;
    logic                     rd_en, wr_en, addr_wrap, last_rd;
    logic [2:0]               occ;

    assign wr_en     = (cnt != 2'd0) && !bus.fifo_full;
    // occupancy the skid will have next cycle if nothing new is issued
    assign occ       = 3'(cnt) + 3'(inflight_q) - 3'(wr_en);
    assign rd_en     = (state_q == RUN) && (occ < 3'd2);
    assign addr_wrap = (addr_q == bram_tf_addr_len'(tf_num - 1));
    assign last_rd   = rd_en && addr_wrap && (pass_q == pass_num_q - bram_addr_len'(1));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pass_d     = pass_q;
        pass_num_d = pass_num_q;
        inflight_d = rd_en;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pass_num_d = bus.pass_num;
                    addr_d     = '0;
                    pass_d     = '0;
                    state_d    = (bus.pass_num == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (rd_en) begin
                    addr_d = addr_wrap ? '0 : addr_q + 1'b1;
                    if (addr_wrap) pass_d = pass_q + 1'b1;
                end
                if (last_rd) state_d = DRAIN;
            end
            // leave once the skid will be empty and nothing is in flight next cycle
            DRAIN:   if (occ == 3'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            pass_q     <= '0;
            pass_num_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pass_q     <= pass_d;
            pass_num_q <= pass_num_d;
            inflight_q <= inflight_d;
        end
    end

    tf_skid2 #(.W(2*float_len)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (bus.tf_data),
        .pop       (wr_en),
        .head      (head),
        .cnt       (cnt)
    );

    assign bus.busy       = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done       = (state_q == DONE);
    assign bus.tf_rd_en   = rd_en;
    assign bus.tf_addr    = addr_q;
    assign bus.fifo_wr_en = wr_en;
    assign bus.fifo_din   = head;
endmodule

// File: tb/tb_tf_fetch.sv
// Directed bench for tf_fetch: table of runs checked against hand-derived
// cycle numbers, plus reset-mid-run and start/pass_num-while-busy sequences.
module tb_tf_fetch;
    import tf_fetch_pkg::*;

    localparam int RUNLEN = 40;
    localparam int LOGN   = RUNLEN + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tf_fetch_if bus ();

    tf_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    function automatic logic [63:0] word(input int i);
        return {32'(i), ~32'(i)};
    endfunction

    // ROM model: registered read, data valid one cycle after tf_rd_en
    always @(posedge clk) if (bus.tf_rd_en) bus.tf_data <= word(int'(bus.tf_addr));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit logging = 1'b0;

    logic        lg_wr [LOGN];
    logic        lg_rd [LOGN];
    logic        lg_busy [LOGN];
    logic        lg_done [LOGN];
    logic        lg_full [LOGN];
    logic [2:0]  lg_addr [LOGN];
    logic [63:0] lg_din [LOGN];

    always @(negedge clk) begin
        if (logging && cyc >= 0 && cyc < LOGN) begin
            lg_wr[cyc]   = bus.fifo_wr_en;
            lg_rd[cyc]   = bus.tf_rd_en;
            lg_busy[cyc] = bus.busy;
            lg_done[cyc] = bus.done;
            lg_full[cyc] = bus.fifo_full;
            lg_addr[cyc] = bus.tf_addr;
            lg_din[cyc]  = bus.fifo_din;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // start in cycle 0; fifo_full high in [flo,fhi]; start re-asserted in [slo,shi]
    // and pass_num altered from slo on
    task automatic run(input int p, input int flo, input int fhi, input int slo, input int shi);
        cyc           = 0;
        bus.start     = 1'b1;
        bus.pass_num  = 13'(p);
        bus.fifo_full = (0 >= flo && 0 <= fhi);
        logging       = 1'b1;
        while (cyc < RUNLEN) begin
            step();
            bus.start     = (cyc >= slo && cyc <= shi);
            if (slo >= 0 && cyc >= slo) bus.pass_num = 13'(p + 4);
            bus.fifo_full = (cyc >= flo && cyc <= fhi);
        end
        step();
        logging       = 1'b0;
        bus.start     = 1'b0;
        bus.fifo_full = 1'b0;
    endtask

    task automatic check_run(input string tag, input int p, input int flo, input int fhi,
                             input int exp_done, input int exp_last_wr);
        int nw = 0, nr = 0, mism = 0, addr_bad = 0, ndone = 0, donec = -1;
        int busy_bad = 0, full_wr = 0, rd_in_full = 0, first_wr = -1, last_wr = -1;
        for (int c = 0; c <= RUNLEN; c++) begin
            if (lg_wr[c]) begin
                if (lg_din[c] !== word(nw % tf_num)) mism++;
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                nw++;
                if (lg_full[c]) full_wr++;
            end
            if (lg_rd[c]) begin
                if (int'(lg_addr[c]) != nr % tf_num) addr_bad++;
                nr++;
                if (c >= flo && c <= fhi) rd_in_full++;
            end
            if (lg_done[c]) begin
                ndone++;
                if (donec < 0) donec = c;
            end
            if (lg_busy[c] !== (c >= 1 && c < exp_done)) busy_bad++;
        end
        chk({tag, ".writes"},     nw, tf_num * p);
        chk({tag, ".reads"},      nr, tf_num * p);
        chk({tag, ".word_order"}, mism, 0);
        chk({tag, ".addr_order"}, addr_bad, 0);
        chk({tag, ".done_cycle"}, donec, exp_done);
        chk({tag, ".done_count"}, ndone, 1);
        chk({tag, ".busy_window"}, busy_bad, 0);
        chk({tag, ".wr_while_full"}, full_wr, 0);
        if (p > 0) begin
            chk({tag, ".first_wr"}, first_wr, 3);
            chk({tag, ".last_wr"},  last_wr, exp_last_wr);
        end
        if (flo >= 0) chk({tag, ".rd_while_full"}, rd_in_full, 0);
    endtask

    typedef struct {
        int p;
        int flo;
        int fhi;
        int exp_done;
        int exp_last_wr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int err;
        vecs[0] = '{p: 1, flo: -1, fhi: -1, exp_done: 11, exp_last_wr: 10};
        vecs[1] = '{p: 3, flo: -1, fhi: -1, exp_done: 27, exp_last_wr: 26};
        vecs[2] = '{p: 1, flo:  4, fhi: 12, exp_done: 20, exp_last_wr: 19};
        vecs[3] = '{p: 0, flo: -1, fhi: -1, exp_done:  1, exp_last_wr: -1};
        vecs[4] = '{p: 2, flo: -1, fhi: -1, exp_done: 19, exp_last_wr: 18};

        bus.start     = 1'b0;
        bus.pass_num  = '0;
        bus.fifo_full = 1'b0;

        #3;
        chk("rst.busy",  bus.busy, 0);
        chk("rst.done",  bus.done, 0);
        chk("rst.rd_en", bus.tf_rd_en, 0);
        chk("rst.wr_en", bus.fifo_wr_en, 0);
        chk("rst.addr",  bus.tf_addr, 0);
        chk("rst.din",   bus.fifo_din, 0);
        step();
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            run(vecs[i].p, vecs[i].flo, vecs[i].fhi, -1, -1);
            check_run($sformatf("vec%0d", i), vecs[i].p, vecs[i].flo, vecs[i].fhi,
                      vecs[i].exp_done, vecs[i].exp_last_wr);
        end

        // reset in cycle 5 of a pass_num=2 run
        cyc          = 0;
        bus.start    = 1'b1;
        bus.pass_num = 13'd2;
        step();
        bus.start = 1'b0;
        while (cyc < 5) step();
        chk("mid.pre_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("mid.busy",  bus.busy, 0);
        chk("mid.done",  bus.done, 0);
        chk("mid.rd_en", bus.tf_rd_en, 0);
        chk("mid.wr_en", bus.fifo_wr_en, 0);
        chk("mid.addr",  bus.tf_addr, 0);
        chk("mid.din",   bus.fifo_din, 0);
        step();
        step();
        rst = 1'b0;
        err = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.done || bus.busy || bus.fifo_wr_en || bus.tf_rd_en) err++;
        end
        chk("mid.quiet_after_rst", err, 0);
        run(2, -1, -1, -1, -1);
        check_run("restart", 2, -1, -1, 19, 18);

        // start spam and pass_num change while busy are ignored
        run(1, -1, -1, 2, 8);
        check_run("spam", 1, -1, -1, 11, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
